// File: rtl/pmu_i2c_target.sv
`default_nettype none
// ============================================================================
//  Module   : pmu_i2c_target
//  Purpose  : I2C target emulating the PMU register interface. Decodes
//             START/STOP, matches a 7-bit device address, accepts
//             subaddress + data writes and serves register reads. A host
//             port gives direct access to the byte-wide register file.
//  Revision : 1.0 - initial release
// ============================================================================
module pmu_i2c_target #(
  parameter logic [6:0] DEV_ADDR      = 7'h34,
  parameter int         REG_ADDR_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scl,
  inout  wire                      sda,
  input  logic [REG_ADDR_BITS-1:0] host_addr,
  input  logic [7:0]               host_wdata,
  input  logic                     host_we,
  output logic [7:0]               host_rdata,
  output logic                     wr_strobe,
  output logic [REG_ADDR_BITS-1:0] wr_addr,
  output logic [7:0]               wr_data,
  output logic                     busy
);

  localparam int DEPTH = 1 << REG_ADDR_BITS;
  localparam logic [REG_ADDR_BITS-1:0] PTR_ONE = {{(REG_ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ADDR       = 4'd1,
    S_ADDR_ACK   = 4'd2,
    S_SUB        = 4'd3,
    S_SUB_ACK    = 4'd4,
    S_WDATA      = 4'd5,
    S_WDATA_ACK  = 4'd6,
    S_RDATA      = 4'd7,
    S_RDATA_MACK = 4'd8
  } state_t;

  // Input conditioning
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, sda_rise, sda_fall;
  logic       start_det, stop_det;

  // Protocol engine state
  state_t                   state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               shift_q, shift_d;
  logic [REG_ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                     ptr_valid_q, ptr_valid_d;
  logic                     phase_q, phase_d;      // second half of an ACK slot / last read bit seen
  logic                     ack_en_q, ack_en_d;    // pull sda low during the pending ACK slot
  logic                     drive_low_q, drive_low_d;
  logic                     busy_q, busy_d;
  logic                     wr_strobe_q, wr_strobe_d;
  logic [REG_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]               wr_data_q, wr_data_d;

  // Register file
  logic [7:0] mem_q [DEPTH];
  logic       mem_we;
  logic [7:0] byte_in;
  logic [7:0] rd_byte;

  // Two-flop synchronizers plus previous-value registers; idle bus is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign sda_rise  = sda_s & ~sda_prev_q;
  assign sda_fall  = ~sda_s & sda_prev_q;
  assign start_det = sda_fall & scl_s & scl_prev_q;
  assign stop_det  = sda_rise & scl_s & scl_prev_q;

  assign byte_in = {shift_q[6:0], sda_s};
  assign rd_byte = ptr_valid_q ? mem_q[ptr_q] : 8'hFF;

  // State register and protocol datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd7;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      ptr_valid_q <= 1'b1;
      phase_q     <= 1'b0;
      ack_en_q    <= 1'b0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      ptr_valid_q <= ptr_valid_d;
      phase_q     <= phase_d;
      ack_en_q    <= ack_en_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Next-state decode: bus conditions first, then per-state bit handling
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    ptr_valid_d = ptr_valid_q;
    phase_d     = phase_q;
    ack_en_d    = ack_en_q;
    drive_low_d = drive_low_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    if (start_det) begin
      state_d     = S_ADDR;
      bit_cnt_d   = 3'd7;
      phase_d     = 1'b0;
      drive_low_d = 1'b0;
    end else if (stop_det) begin
      state_d     = S_IDLE;
      phase_d     = 1'b0;
      drive_low_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          drive_low_d = 1'b0;
        end

        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              phase_d = 1'b0;
              if (byte_in[7:1] == DEV_ADDR) begin
                state_d  = S_ADDR_ACK;
                ack_en_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        end

        S_SUB: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              ptr_d       = byte_in[REG_ADDR_BITS-1:0];
              ptr_valid_d = ~|byte_in[7:REG_ADDR_BITS];
              ack_en_d    = 1'b1;
              phase_d     = 1'b0;
              state_d     = S_SUB_ACK;
            end
          end
        end

        S_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              if (ptr_valid_q) begin
                mem_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = byte_in;
                ptr_d       = ptr_q + PTR_ONE;
              end
              ack_en_d = ptr_valid_q;
              phase_d  = 1'b0;
              state_d  = S_WDATA_ACK;
            end
          end
        end

        S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: begin
          // First fall opens the ACK slot, second fall closes it
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d     = 1'b1;
              drive_low_d = ack_en_q;
            end else begin
              phase_d     = 1'b0;
              drive_low_d = 1'b0;
              bit_cnt_d   = 3'd7;
              if (state_q == S_ADDR_ACK && shift_q[0]) begin
                state_d     = S_RDATA;
                shift_d     = rd_byte;
                drive_low_d = ~rd_byte[7];
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_SUB;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end

        S_RDATA: begin
          if (scl_rise) begin
            if (bit_cnt_q == 3'd0) begin
              phase_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else if (scl_fall) begin
            if (phase_q) begin
              phase_d     = 1'b0;
              drive_low_d = 1'b0;
              state_d     = S_RDATA_MACK;
            end else begin
              shift_d     = {shift_q[6:0], 1'b1};
              drive_low_d = ~shift_q[6];
            end
          end
        end

        S_RDATA_MACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              phase_d = 1'b1;
              ptr_d   = ptr_q + PTR_ONE;
            end else begin
              state_d = S_IDLE;
            end
          end else if (scl_fall && phase_q) begin
            phase_d     = 1'b0;
            bit_cnt_d   = 3'd7;
            shift_d     = rd_byte;
            drive_low_d = ~rd_byte[7];
            state_d     = S_RDATA;
          end
        end

        default: begin
          state_d     = S_IDLE;
          drive_low_d = 1'b0;
        end
      endcase
    end
  end

  // Register file: host writes first so a same-cycle I2C write to the same index wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      if (host_we) begin
        mem_q[host_addr] <= host_wdata;
      end
      if (mem_we) begin
        mem_q[ptr_q] <= byte_in;
      end
    end
  end

  // Open-drain output; reset gates the drive so release is immediate
  assign sda = (drive_low_q && !reset) ? 1'b0 : 1'bz;

  assign host_rdata = mem_q[host_addr];
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pmu_i2c_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmu_i2c_target
//  Purpose  : Self-checking bench for pmu_i2c_target: directed vector table,
//             hand-written corner sequences and randomized transactions
//             checked against a transaction-level register model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pmu_i2c_target;

  localparam int Q = 5;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic [5:0] host_addr = 6'h00;
  logic [7:0] host_wdata = 8'h00;
  logic       host_we = 1'b0;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int total = 0;
  int bad = 0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  pmu_i2c_target #(.DEV_ADDR(7'h34), .REG_ADDR_BITS(6)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we),
    .host_rdata(host_rdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  typedef struct packed {logic [5:0] a; logic [7:0] d;} stb_t;
  stb_t stb_q[$];
  bit   busy_seen = 1'b0;

  // Record committed bytes and any busy activity
  always @(negedge clk) begin
    if (wr_strobe) stb_q.push_back({wr_addr, wr_data});
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    m_low = 1'b1; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    m_low = 1'b0; wait_clk(Q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_low = ~b[i]; wait_clk(Q);
      scl = 1'b1;    wait_clk(2 * Q);
      scl = 1'b0;    wait_clk(Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    write_bits(b, 8);
    m_low = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    ack = (sda === 1'b0);
    wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic read_byte(input logic nak, output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q); scl = 1'b1;
      wait_clk(Q); b[i] = (sda === 1'b0) ? 1'b0 : 1'b1;
      wait_clk(Q); scl = 1'b0;
    end
    wait_clk(Q); m_low = ~nak;
    wait_clk(Q); scl = 1'b1;
    wait_clk(2 * Q); scl = 1'b0;
    wait_clk(Q); m_low = 1'b0;
  endtask

  task automatic peek(input logic [5:0] a, output logic [7:0] v);
    host_addr = a;
    wait_clk(1);
    v = host_rdata;
  endtask

  // Directed table: one write transaction per record, then STOP
  typedef struct packed {
    logic [7:0] dev;
    logic [7:0] sub;
    logic [1:0] nd;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] acks;   // [3]=device, [2]=sub, [1]=data0, [0]=data1
    logic [1:0] nstb;
    logic [5:0] chk_a;
    logic [7:0] chk_v;
    logic       busy_exp;
  } vec_t;

  localparam int NV = 5;
  vec_t vec [NV];

  // Transaction-level model used by the randomized phase
  logic [7:0] mm [64];
  int         mptr;
  bit         mvalid;

  initial begin
    logic       ack;
    logic [7:0] rb;
    logic [7:0] v8;
    stb_t       exp_q[$];

    vec[0] = '{8'h68, 8'h10, 2'd1, 8'h9D, 8'h00, 4'b1110, 2'd1, 6'h10, 8'h9D, 1'b1};
    vec[1] = '{8'h68, 8'h80, 2'd1, 8'h11, 8'h00, 4'b1100, 2'd0, 6'h00, 8'h00, 1'b1};
    vec[2] = '{8'h50, 8'h10, 2'd2, 8'h11, 8'h22, 4'b0000, 2'd0, 6'h10, 8'h9D, 1'b0};
    vec[3] = '{8'h68, 8'h3F, 2'd2, 8'hA1, 8'hB2, 4'b1111, 2'd2, 6'h00, 8'hB2, 1'b1};
    vec[4] = '{8'h68, 8'h05, 2'd2, 8'hC3, 8'h3C, 4'b1111, 2'd2, 6'h06, 8'h3C, 1'b1};

    // Reset state
    wait_clk(4);
    check("rst_sda", sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 6'h00);
    check("rst_wr_data", wr_data, 8'h00);
    reset = 1'b0;
    wait_clk(4);
    peek(6'h3F, v8);
    check("rst_reg3f", v8, 8'h00);

    // Table-driven write transactions
    for (int v = 0; v < NV; v++) begin
      stb_q.delete();
      busy_seen = 1'b0;
      i2c_start();
      write_byte(vec[v].dev, ack);
      check($sformatf("v%0d_ack_dev", v), ack, vec[v].acks[3]);
      write_byte(vec[v].sub, ack);
      check($sformatf("v%0d_ack_sub", v), ack, vec[v].acks[2]);
      for (int j = 0; j < int'(vec[v].nd); j++) begin
        write_byte(j == 0 ? vec[v].d0 : vec[v].d1, ack);
        check($sformatf("v%0d_ack_d%0d", v, j), ack, vec[v].acks[1 - j]);
      end
      i2c_stop();
      wait_clk(8);
      check($sformatf("v%0d_nstb", v), stb_q.size(), vec[v].nstb);
      if (vec[v].nstb != 0 && stb_q.size() != 0)
        check($sformatf("v%0d_stb0", v), stb_q[0], {vec[v].sub[5:0], vec[v].d0});
      peek(vec[v].chk_a, v8);
      check($sformatf("v%0d_reg", v), v8, vec[v].chk_v);
      check($sformatf("v%0d_busy_seen", v), busy_seen, vec[v].busy_exp);
      check($sformatf("v%0d_busy_after_stop", v), busy, 1'b0);
    end
    peek(6'h3F, v8);
    check("burst_reg3f", v8, 8'hA1);

    // Host write then I2C read-back with master NAK
    host_addr = 6'h32; host_wdata = 8'h5A; host_we = 1'b1;
    wait_clk(1);
    host_we = 1'b0;
    i2c_start();
    write_byte(8'h68, ack); check("hr_ack_dev", ack, 1'b1);
    write_byte(8'h32, ack); check("hr_ack_sub", ack, 1'b1);
    i2c_stop();
    i2c_start();
    write_byte(8'h69, ack); check("hr_ack_rd", ack, 1'b1);
    read_byte(1'b1, rb);
    check("hr_rdata", rb, 8'h5A);
    wait_clk(Q);
    check("hr_sda_released", sda, 1'b1);
    i2c_stop();

    // STOP after a partial data byte discards it
    stb_q.delete();
    i2c_start();
    write_byte(8'h68, ack); check("part_ack_dev", ack, 1'b1);
    write_byte(8'h10, ack); check("part_ack_sub", ack, 1'b1);
    write_bits(8'h40, 4);
    i2c_stop();
    wait_clk(8);
    check("part_nstb", stb_q.size(), 0);
    peek(6'h10, v8);
    check("part_reg10", v8, 8'h9D);
    i2c_start();
    write_byte(8'h68, ack); check("part_next_ack", ack, 1'b1);
    i2c_stop();

    // Reset in the middle of a read byte (reg 0x10 = 9D, bit 6 is 0)
    i2c_start();
    write_byte(8'h69, ack); check("mid_ack_rd", ack, 1'b1);
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); check("mid_bit7", sda, 1'b1);
    wait_clk(Q); scl = 1'b0;
    wait_clk(Q);
    check("mid_bit6_driven", sda, 1'b0);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_sda_z_on_reset", sda, 1'b1);
    wait_clk(2);
    scl = 1'b1; m_low = 1'b0;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);
    peek(6'h10, v8); check("mid_reg10_cleared", v8, 8'h00);
    peek(6'h32, v8); check("mid_reg32_cleared", v8, 8'h00);
    check("mid_busy_cleared", busy, 1'b0);
    check("mid_wr_addr_cleared", wr_addr, 6'h00);
    check("mid_wr_data_cleared", wr_data, 8'h00);

    // Randomized transactions against the register model
    for (int i = 0; i < 64; i++) mm[i] = 8'h00;
    mptr = 0;
    mvalid = 1'b1;
    for (int t = 0; t < 24; t++) begin
      int kind;
      kind = $urandom_range(0, 4);
      stb_q.delete();
      exp_q.delete();
      if (kind <= 1) begin
        logic [7:0] sub;
        int nd;
        sub = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
        nd = $urandom_range(0, 3);
        i2c_start();
        write_byte(8'h68, ack); check("rw_ack_dev", ack, 1'b1);
        write_byte(sub, ack);   check("rw_ack_sub", ack, 1'b1);
        mptr = int'(sub) % 64;
        mvalid = (sub < 8'd64);
        for (int j = 0; j < nd; j++) begin
          logic [7:0] d;
          d = 8'($urandom);
          write_byte(d, ack);
          check("rw_ack_data", ack, mvalid);
          if (mvalid) begin
            mm[mptr] = d;
            exp_q.push_back({6'(mptr), d});
            mptr = (mptr + 1) % 64;
          end
        end
        i2c_stop();
        wait_clk(8);
        check("rw_nstb", stb_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < stb_q.size(); j++)
          check("rw_stb", stb_q[j], exp_q[j]);
      end else if (kind == 2) begin
        int n;
        if ($urandom_range(0, 1) == 1) begin
          logic [7:0] sub;
          sub = 8'($urandom_range(0, 63));
          i2c_start();
          write_byte(8'h68, ack); check("rr_ack_dev", ack, 1'b1);
          write_byte(sub, ack);   check("rr_ack_sub", ack, 1'b1);
          mptr = int'(sub);
          mvalid = 1'b1;
        end
        i2c_start();
        write_byte(8'h69, ack); check("rr_ack_rd", ack, 1'b1);
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          read_byte(j == n - 1, rb);
          check("rr_data", rb, mvalid ? mm[mptr] : 8'hFF);
          if (j != n - 1) mptr = (mptr + 1) % 64;
        end
        i2c_stop();
        wait_clk(4);
        check("rr_nstb", stb_q.size(), 0);
      end else if (kind == 3) begin
        logic [5:0] a;
        logic [7:0] d;
        a = 6'($urandom);
        d = 8'($urandom);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        wait_clk(1);
        host_we = 1'b0;
        mm[a] = d;
        peek(a, v8);
        check("rh_reg", v8, d);
      end else begin
        logic [6:0] dev;
        dev = 7'($urandom);
        if (dev == 7'h34) dev = 7'h35;
        i2c_start();
        write_byte({dev, 1'($urandom)}, ack);
        check("rn_ack", ack, 1'b0);
        write_byte(8'($urandom), ack);
        check("rn_ack_data", ack, 1'b0);
        i2c_stop();
        wait_clk(4);
        check("rn_nstb", stb_q.size(), 0);
      end
    end

    // Final register file sweep against the model
    for (int i = 0; i < 64; i++) begin
      peek(6'(i), v8);
      check($sformatf("final_reg%0d", i), v8, mm[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
